// File: rtl/scene_sequencer_if.sv
// rtl/scene_sequencer_if.sv - game-logic/renderer bundle for the scene sequencer
// Purpose : groups raster position, scene request handshake, jumpscare level
//           and renderer controls into one bundle.
// Ports   : DrawX/DrawY raster position, req_valid/req_scene/req_ready request
//           handshake, jumpscare trigger level, scene_sel/brightness/static_en
//           renderer controls, busy/game_over status.
// master  : game logic / raster side (drives position, requests, jumpscare).
// slave   : the sequencer.
interface scene_sequencer_if #(
    parameter int SCENE_W = 3
);
    logic [9:0]         DrawX;
    logic [9:0]         DrawY;
    logic               req_valid;
    logic [SCENE_W-1:0] req_scene;
    logic               req_ready;
    logic               jumpscare;
    logic [SCENE_W-1:0] scene_sel;
    logic [3:0]         brightness;
    logic               static_en;
    logic               busy;
    logic               game_over;

    modport master (
        output DrawX, DrawY, req_valid, req_scene, jumpscare,
        input  req_ready, scene_sel, brightness, static_en, busy, game_over
    );

    modport slave (
        input  DrawX, DrawY, req_valid, req_scene, jumpscare,
        output req_ready, scene_sel, brightness, static_en, busy, game_over
    );
endinterface

// File: rtl/scene_sequencer.sv
// rtl/scene_sequencer.sv - frame-synchronous background scene/transition sequencer
// Purpose : picks the background scene, runs fade-out/static/fade-in
//           transitions and the jumpscare/game-over takeover. Visible outputs
//           only change on a frame tick (raster reaching (0,0)).
// Ports   : vga_clk pixel clock, reset async active-high,
//           bus (slave) raster position, request handshake, jumpscare level
//           and registered renderer controls/status.
module scene_sequencer #(
    parameter int NUM_SCENES    = 8,
    parameter int SCENE_W       = 3,
    parameter int INIT_SCENE    = 0,
    parameter int JUMP_SCENE    = 7,
    parameter int FADE_STEP     = 3,
    parameter int STATIC_FRAMES = 2,
    parameter int JUMP_FRAMES   = 60
) (
    input logic              vga_clk,
    input logic              reset,
    scene_sequencer_if.slave bus
);
    localparam int CNT_MAX = (JUMP_FRAMES > STATIC_FRAMES) ? JUMP_FRAMES : STATIC_FRAMES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [3:0]       FS       = 4'(FADE_STEP);
    localparam logic [SCENE_W:0] NUM_W    = (SCENE_W + 1)'(NUM_SCENES);
    localparam logic [SCENE_W-1:0] INIT_S = SCENE_W'(INIT_SCENE);
    localparam logic [SCENE_W-1:0] JUMP_S = SCENE_W'(JUMP_SCENE);

    typedef enum logic [2:0] {
        S_SHOW, S_FADE_OUT, S_STATIC, S_FADE_IN, S_JUMPSCARE, S_GAME_OVER
    } state_t;

    state_t             state_q, state_d;
    logic [SCENE_W-1:0] pend_q, pend_d;
    logic [SCENE_W-1:0] scene_q, scene_d;
    logic [3:0]         bright_q, bright_d;
    logic               static_q, static_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               js_pend_q, js_pend_d;
    logic               js_prev_q;
    logic               origin_prev_q;
    logic               req_ready_q, req_ready_d;
    logic               busy_q, busy_d;
    logic               game_over_q, game_over_d;

    logic at_origin, tick, js_arm, handshake, req_legal;

    assign at_origin = (bus.DrawX == 10'd0) && (bus.DrawY == 10'd0);
    assign tick      = at_origin && !origin_prev_q;
    // Edge only arms the takeover while it has not already happened.
    assign js_arm    = bus.jumpscare && !js_prev_q &&
                       (state_q != S_JUMPSCARE) && (state_q != S_GAME_OVER);
    assign handshake = bus.req_valid && req_ready_q;
    assign req_legal = ({1'b0, bus.req_scene} < NUM_W) && (bus.req_scene != scene_q);

    always_comb begin
        state_d   = state_q;
        pend_d    = pend_q;
        scene_d   = scene_q;
        bright_d  = bright_q;
        static_d  = static_q;
        cnt_d     = cnt_q;
        js_pend_d = js_pend_q | js_arm;

        if (tick && js_pend_q) begin
            // Takeover wins over any fade/static step on this tick.
            state_d   = S_JUMPSCARE;
            scene_d   = JUMP_S;
            bright_d  = 4'd15;
            static_d  = 1'b0;
            cnt_d     = CNT_W'(JUMP_FRAMES);
            js_pend_d = 1'b0;
        end else begin
            unique case (state_q)
                S_SHOW: begin
                    // A request accepted alongside a jumpscare edge is swallowed.
                    if (handshake && req_legal && !js_arm) begin
                        pend_d  = bus.req_scene;
                        state_d = S_FADE_OUT;
                    end
                end
                S_FADE_OUT: begin
                    if (tick) begin
                        if (bright_q <= FS) begin
                            bright_d = 4'd0;
                            scene_d  = pend_q;
                            static_d = 1'b1;
                            cnt_d    = CNT_W'(STATIC_FRAMES);
                            state_d  = S_STATIC;
                        end else begin
                            bright_d = bright_q - FS;
                        end
                    end
                end
                S_STATIC: begin
                    if (tick) begin
                        if (cnt_q == CNT_W'(1)) begin
                            static_d = 1'b0;
                            state_d  = S_FADE_IN;
                        end else begin
                            cnt_d = cnt_q - CNT_W'(1);
                        end
                    end
                end
                S_FADE_IN: begin
                    if (tick) begin
                        if (bright_q >= (4'd15 - FS)) begin
                            bright_d = 4'd15;
                            state_d  = S_SHOW;
                        end else begin
                            bright_d = bright_q + FS;
                        end
                    end
                end
                S_JUMPSCARE: begin
                    if (tick) begin
                        if (cnt_q == CNT_W'(1)) begin
                            bright_d = 4'd0;
                            static_d = 1'b0;
                            state_d  = S_GAME_OVER;
                        end else begin
                            cnt_d = cnt_q - CNT_W'(1);
                        end
                    end
                end
                S_GAME_OVER: begin
                    bright_d = 4'd0;
                    static_d = 1'b0;
                end
                default: state_d = S_SHOW;
            endcase
        end

        // Status is registered from next state so it lines up with the change.
        req_ready_d = (state_d == S_SHOW) && !js_pend_d;
        busy_d      = (state_d != S_SHOW) || js_pend_d;
        game_over_d = (state_d == S_GAME_OVER);
    end

    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_SHOW;
            pend_q        <= INIT_S;
            scene_q       <= INIT_S;
            bright_q      <= 4'd15;
            static_q      <= 1'b0;
            cnt_q         <= '0;
            js_pend_q     <= 1'b0;
            js_prev_q     <= 1'b0;
            origin_prev_q <= 1'b0;
            req_ready_q   <= 1'b1;
            busy_q        <= 1'b0;
            game_over_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            pend_q        <= pend_d;
            scene_q       <= scene_d;
            bright_q      <= bright_d;
            static_q      <= static_d;
            cnt_q         <= cnt_d;
            js_pend_q     <= js_pend_d;
            js_prev_q     <= bus.jumpscare;
            origin_prev_q <= at_origin;
            req_ready_q   <= req_ready_d;
            busy_q        <= busy_d;
            game_over_q   <= game_over_d;
        end
    end

    assign bus.req_ready  = req_ready_q;
    assign bus.scene_sel  = scene_q;
    assign bus.brightness = bright_q;
    assign bus.static_en  = static_q;
    assign bus.busy       = busy_q;
    assign bus.game_over  = game_over_q;
endmodule

// File: tb/tb_scene_sequencer.sv
// tb/tb_scene_sequencer.sv - directed self-checking bench for scene_sequencer
module tb_scene_sequencer;
    localparam int SW = 4;

    logic clk;
    logic rst;
    int   tests;
    int   fails;

    scene_sequencer_if #(.SCENE_W(SW)) bus ();

    scene_sequencer #(
        .NUM_SCENES(8), .SCENE_W(SW), .INIT_SCENE(0), .JUMP_SCENE(7),
        .FADE_STEP(3), .STATIC_FRAMES(2), .JUMP_FRAMES(60)
    ) dut (
        .vga_clk(clk),
        .reset  (rst),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One idle cycle then one cycle at the origin; returns just after the tick edge.
    task automatic frame();
        bus.DrawX = 10'd1;
        bus.DrawY = 10'd0;
        step();
        bus.DrawX = 10'd0;
        bus.DrawY = 10'd0;
        step();
        bus.DrawX = 10'd1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic request(input int s);
        bus.req_valid = 1'b1;
        bus.req_scene = SW'(s);
        step();
        bus.req_valid = 1'b0;
    endtask

    int exp_fo[5] = '{12, 9, 6, 3, 0};
    int exp_fi[5] = '{3, 6, 9, 12, 15};

    initial begin
        tests = 0;
        fails = 0;
        rst = 1'b1;
        bus.DrawX = 10'd1;
        bus.DrawY = 10'd0;
        bus.req_valid = 1'b0;
        bus.req_scene = '0;
        bus.jumpscare = 1'b0;
        do_reset();

        check("rst_scene", 32'(bus.scene_sel), 0);
        check("rst_bright", 32'(bus.brightness), 15);
        check("rst_static", 32'(bus.static_en), 0);
        check("rst_ready", 32'(bus.req_ready), 1);
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_gameover", 32'(bus.game_over), 0);

        // Asynchronous reset in the middle of a fade-out.
        request(3);
        for (int i = 0; i < 3; i++) frame();
        check("t1_pre_bright", 32'(bus.brightness), 6);
        rst = 1'b1;
        #1;
        check("t1_bright", 32'(bus.brightness), 15);
        check("t1_scene", 32'(bus.scene_sel), 0);
        check("t1_static", 32'(bus.static_en), 0);
        check("t1_ready", 32'(bus.req_ready), 1);
        check("t1_busy", 32'(bus.busy), 0);
        step();
        rst = 1'b0;
        step();

        // Same-scene and out-of-range requests are accepted and dropped.
        bus.req_valid = 1'b1;
        bus.req_scene = SW'(0);
        step();
        check("t3_same_ready", 32'(bus.req_ready), 1);
        check("t3_same_busy", 32'(bus.busy), 0);
        bus.req_scene = SW'(9);
        step();
        check("t3_oor_ready", 32'(bus.req_ready), 1);
        check("t3_oor_busy", 32'(bus.busy), 0);
        bus.req_valid = 1'b0;
        frame();
        check("t3_bright", 32'(bus.brightness), 15);
        check("t3_scene", 32'(bus.scene_sel), 0);

        // Full transition 0 -> 3.
        request(3);
        check("t2_ready_after_accept", 32'(bus.req_ready), 0);
        check("t2_busy", 32'(bus.busy), 1);
        check("t2_bright_accept", 32'(bus.brightness), 15);
        for (int i = 0; i < 5; i++) begin
            frame();
            check($sformatf("t2_fo%0d", i + 1), 32'(bus.brightness), 32'(exp_fo[i]));
            if (i == 3) check("t2_scene_before", 32'(bus.scene_sel), 0);
        end
        check("t2_scene_swap", 32'(bus.scene_sel), 3);
        check("t2_static_on", 32'(bus.static_en), 1);
        frame();
        check("t2_static_t6", 32'(bus.static_en), 1);
        frame();
        check("t2_static_t7", 32'(bus.static_en), 0);
        check("t2_bright_t7", 32'(bus.brightness), 0);
        for (int i = 0; i < 5; i++) begin
            frame();
            check($sformatf("t2_fi%0d", i + 1), 32'(bus.brightness), 32'(exp_fi[i]));
            if (i < 4) check($sformatf("t2_fi_ready%0d", i + 1), 32'(bus.req_ready), 0);
        end
        check("t2_ready_end", 32'(bus.req_ready), 1);
        check("t2_busy_end", 32'(bus.busy), 0);

        // Request held across a transition; second request waits for SHOW.
        bus.req_valid = 1'b1;
        bus.req_scene = SW'(1);
        step();
        bus.req_scene = SW'(6);
        for (int i = 0; i < 12; i++) begin
            check($sformatf("t4_ready_f%0d", i), 32'(bus.req_ready), 0);
            frame();
        end
        check("t4_scene1", 32'(bus.scene_sel), 1);
        check("t4_ready_show", 32'(bus.req_ready), 1);
        step();
        bus.req_valid = 1'b0;
        check("t4_ready_second", 32'(bus.req_ready), 0);
        check("t4_busy_second", 32'(bus.busy), 1);
        frame();
        check("t4_second_fade", 32'(bus.brightness), 12);

        // Jumpscare during STATIC, then game over.
        for (int i = 0; i < 4; i++) frame();
        check("t5_in_static", 32'(bus.static_en), 1);
        check("t5_static_scene", 32'(bus.scene_sel), 6);
        bus.jumpscare = 1'b1;
        step();
        check("t5_busy", 32'(bus.busy), 1);
        frame();
        check("t5_js_scene", 32'(bus.scene_sel), 7);
        check("t5_js_bright", 32'(bus.brightness), 15);
        check("t5_js_static", 32'(bus.static_en), 0);
        for (int i = 0; i < 59; i++) frame();
        check("t5_go_early", 32'(bus.game_over), 0);
        frame();
        check("t5_go", 32'(bus.game_over), 1);
        check("t5_go_bright", 32'(bus.brightness), 0);
        check("t5_go_ready", 32'(bus.req_ready), 0);
        bus.req_valid = 1'b1;
        bus.req_scene = SW'(2);
        for (int i = 0; i < 4; i++) begin
            bus.jumpscare = ~bus.jumpscare;
            frame();
        end
        bus.req_valid = 1'b0;
        check("t5_hold_go", 32'(bus.game_over), 1);
        check("t5_hold_scene", 32'(bus.scene_sel), 7);
        check("t5_hold_bright", 32'(bus.brightness), 0);
        check("t5_hold_ready", 32'(bus.req_ready), 0);

        // Accept and jumpscare edge in the same cycle.
        bus.jumpscare = 1'b0;
        do_reset();
        check("t6_rst_go", 32'(bus.game_over), 0);
        bus.jumpscare = 1'b1;
        request(4);
        check("t6_ready", 32'(bus.req_ready), 0);
        check("t6_busy", 32'(bus.busy), 1);
        check("t6_scene_hold", 32'(bus.scene_sel), 0);
        frame();
        check("t6_js_scene", 32'(bus.scene_sel), 7);
        check("t6_js_bright", 32'(bus.brightness), 15);
        frame();
        check("t6_js_scene2", 32'(bus.scene_sel), 7);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/scene_sequencer.md
Name: scene_sequencer

Overview:
- Sequences which full-screen background image the renderer draws: camera/scene switches, fade-out/static/fade-in transitions and the jumpscare/game-over takeover.
- Sits between game logic and the per-scene ROM/palette renderers.
- Outputs a scene select, a 4-bit brightness scale and a static-noise enable.
- All visible outputs change only at frame boundaries, so no frame is drawn with mixed settings.

Parameters:
- NUM_SCENES, 8, number of selectable scenes; legal indices are 0..NUM_SCENES-1.
- SCENE_W, 3, width of scene index ports.
- INIT_SCENE, 0, scene shown after reset.
- JUMP_SCENE, 7, scene index forced during jumpscare.
- FADE_STEP, 3, brightness change per frame during fades (1..15).
- STATIC_FRAMES, 2, frames of static between fade-out and fade-in (>=1).
- JUMP_FRAMES, 60, frames jumpscare is held before game over (>=1).

Ports:
- vga_clk  in  1  pixel clock.
- reset  in  1  asynchronous, active-high reset.
- DrawX  in  10  current pixel column.
- DrawY  in  10  current pixel row.
- req_valid  in  1  scene change request valid.
- req_scene  in  SCENE_W  requested scene index.
- req_ready  out  1  sequencer accepts a request this cycle.
- jumpscare  in  1  level from game logic; its rising edge triggers jumpscare.
- scene_sel  out  SCENE_W  scene the renderer draws.
- brightness  out  4  0 = black, 15 = full; renderer scales palette output by it.
- static_en  out  1  renderer overlays static noise.
- busy  out  1  high in any state other than SHOW.
- game_over  out  1  latched high in GAME_OVER.

Behaviour:
- Reset is asynchronous and takes effect immediately, including mid-transition. Reset values:
  - scene_sel=INIT_SCENE, brightness=15, static_en=0.
  - req_ready=1, busy=0, game_over=0.
  - state SHOW; pending and jumpscare flags cleared.
- Frame tick:
  - One-cycle internal pulse on the first cycle where DrawX==0 && DrawY==0, with the registered previous cycle not at (0,0).
  - All state transitions except request accept happen only on a tick.
- All outputs are registered.
- States:
  - SHOW:
    - req_ready=1.
    - Handshake = req_valid && req_ready.
    - Accepted index >= NUM_SCENES or == scene_sel: dropped, stay in SHOW.
    - Otherwise latch it as pending, go to FADE_OUT in that same cycle; req_ready=0 from the next cycle.
    - A tick coinciding with the accept does not count as a fade step.
  - FADE_OUT:
    - Each tick: brightness -= FADE_STEP, saturating at 0.
    - On the tick brightness reaches 0: scene_sel<=pending, static_en<=1, frame counter loaded, go to STATIC.
  - STATIC:
    - Counts STATIC_FRAMES ticks.
    - On the last counted tick: static_en<=0, go to FADE_IN (brightness stays 0).
  - FADE_IN:
    - Each tick: brightness += FADE_STEP, saturating at 15.
    - On the tick it reaches 15: go to SHOW; req_ready=1 from the next cycle.
  - JUMPSCARE:
    - scene_sel=JUMP_SCENE, brightness=15, static_en=0.
    - Counts JUMP_FRAMES ticks, then GAME_OVER.
  - GAME_OVER:
    - brightness=0, static_en=0, game_over=1, req_ready=0.
    - Terminal until reset.
- Jumpscare:
  - A rising edge of jumpscare (registered compare) in any state except JUMPSCARE/GAME_OVER sets a pending flag; req_ready=0 from the next cycle.
  - At the next tick: enter JUMPSCARE from any state, discarding any pending scene and fade progress.
  - A handshake in the same cycle as the edge completes, but its scene is discarded.
  - Jumpscare outranks a simultaneous fade/static step.
- busy = state != SHOW, or jumpscare pending.

Test Plan:
1. Reset mid-FADE_OUT (brightness=6) -> same cycle: brightness=15, scene_sel=0, static_en=0, req_ready=1, busy=0.
2. SHOW scene 0; request scene 3 (FADE_STEP=3, STATIC_FRAMES=2):
   - Ticks 1..5: brightness 12,9,6,3,0; tick 5: scene_sel=3, static_en=1.
   - Tick 7: static_en=0.
   - Ticks 8..12: brightness 3,6,9,12,15.
   - req_ready=1 the cycle after tick 12.
3. Request scene 0 while showing 0, and request scene 9 -> both accepted in one cycle each; no state change; brightness stays 15; scene_sel stays 0.
4. req_valid held during a transition -> req_ready=0 throughout; request accepted only in the first SHOW cycle; second transition starts then.
5. Jumpscare edge during STATIC -> next tick: scene_sel=7, brightness=15, static_en=0. After 60 more ticks: game_over=1, brightness=0. Remains there with further requests and jumpscare toggles until reset.
6. Accept and jumpscare edge in the same cycle -> scene_sel never shows the requested scene; JUMPSCARE entered at the next tick.
